// File: rtl/imem_bridge_pkg.sv
// imem_bridge_pkg: shared constants, line type and FSM states for the instruction-memory bridge
package imem_bridge_pkg;
  localparam int FETCH_WIDTH = 2;
  localparam int CPU_ADDR_BITS = 32;
  localparam int CPU_INST_BITS = 32;
  localparam int IMEM_RSP_FIFO_DEPTH = 2;
  localparam int LINE_BITS = FETCH_WIDTH * CPU_INST_BITS;
  typedef logic [FETCH_WIDTH-1:0][CPU_INST_BITS-1:0] imem_line_t;
  typedef enum logic {IBR_IDLE, IBR_FETCH} imem_bridge_state_t;
endpackage

// File: rtl/imem_bridge_if.sv
// imem_bridge_if: core fetch, backing memory and error signals of the bridge
interface imem_bridge_if;
  import imem_bridge_pkg::*;
  logic imem_req_val;
  logic imem_req_rdy;
  logic [CPU_ADDR_BITS-1:0] imem_req_packet;
  logic imem_rec_val;
  logic imem_rec_rdy;
  logic [LINE_BITS-1:0] imem_rec_packet;
  logic mem_req_val;
  logic mem_req_rdy;
  logic [CPU_ADDR_BITS-1:0] mem_req_addr;
  logic mem_rsp_val;
  logic [CPU_INST_BITS-1:0] mem_rsp_data;
  logic err;
  modport slave (
    input imem_req_val, imem_req_packet, imem_rec_rdy, mem_req_rdy, mem_rsp_val, mem_rsp_data,
    output imem_req_rdy, imem_rec_val, imem_rec_packet, mem_req_val, mem_req_addr, err
  );
  modport master (
    output imem_req_val, imem_req_packet, imem_rec_rdy, mem_req_rdy, mem_rsp_val, mem_rsp_data,
    input imem_req_rdy, imem_rec_val, imem_rec_packet, mem_req_val, mem_req_addr, err
  );
endinterface

// File: rtl/imem_bridge_line_fifo.sv
// line_fifo: synchronous width/depth FIFO with count, async active-high reset
module line_fifo #(
  parameter int W = 64,
  parameter int D = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(D+1)-1:0] count
);
  localparam int PW = D > 1 ? $clog2(D) : 1;
  localparam int CW = $clog2(D+1);
  logic [W-1:0] mem [D];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(D);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = empty ? '0 : mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp == PW'(D-1) ? '0 : wp + PW'(1);
      if (do_pop) rp <= rp == PW'(D-1) ? '0 : rp + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/imem_bridge.sv
// imem_bridge: turns one fetch request into FETCH_WIDTH word reads and queues the assembled line
module imem_bridge
  import imem_bridge_pkg::*;
(
  input logic clk,
  input logic rst,
  imem_bridge_if.slave bus
);
  localparam int CW = $clog2(FETCH_WIDTH+1);
  localparam int SW = FETCH_WIDTH > 1 ? $clog2(FETCH_WIDTH) : 1;
  localparam int FCW = $clog2(IMEM_RSP_FIFO_DEPTH+1);
  imem_bridge_state_t state, state_n;
  logic [CPU_ADDR_BITS-1:0] base;
  logic [CW-1:0] issue_cnt, rsp_cnt;
  logic [SW-1:0] slot;
  imem_line_t line_q, line_d;
  logic err, fetching, accept, issue, rsp_ok, last;
  logic fifo_full, fifo_empty;
  logic [FCW-1:0] fifo_count;
  assign fetching = state == IBR_FETCH;
  assign accept = bus.imem_req_val && bus.imem_req_rdy;
  assign issue = bus.mem_req_val && bus.mem_req_rdy;
  // a response is only legal while it matches an already-issued read
  assign rsp_ok = bus.mem_rsp_val && fetching && rsp_cnt < issue_cnt;
  assign last = rsp_ok && rsp_cnt == CW'(FETCH_WIDTH-1);
  assign slot = rsp_cnt[SW-1:0];
  assign bus.imem_req_rdy = state == IBR_IDLE && fifo_count < FCW'(IMEM_RSP_FIFO_DEPTH);
  assign bus.mem_req_val = fetching && issue_cnt < CW'(FETCH_WIDTH);
  assign bus.mem_req_addr = bus.mem_req_val ? base + CPU_ADDR_BITS'({issue_cnt, 2'b00}) : '0;
  assign bus.imem_rec_val = !fifo_empty;
  assign bus.err = err;
  always_comb begin
    line_d = line_q;
    if (rsp_ok) line_d[slot] = bus.mem_rsp_data;
    state_n = accept ? IBR_FETCH : last ? IBR_IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IBR_IDLE;
      base <= '0;
      issue_cnt <= '0;
      rsp_cnt <= '0;
      line_q <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      err <= err | (bus.mem_rsp_val && !rsp_ok);
      if (accept) begin
        base <= {bus.imem_req_packet[CPU_ADDR_BITS-1:2], 2'b00};
        issue_cnt <= '0;
        rsp_cnt <= '0;
        line_q <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + CW'(1);
        if (rsp_ok) rsp_cnt <= rsp_cnt + CW'(1);
        line_q <= line_d;
      end
    end
  end
  line_fifo #(.W(LINE_BITS), .D(IMEM_RSP_FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(last && !fifo_full),
    .pop(bus.imem_rec_val && bus.imem_rec_rdy),
    .wdata(line_d),
    .rdata(bus.imem_rec_packet),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
endmodule

// File: doc/imem_bridge.md
Name: imem_bridge

Overview:
- Sits between the core's instruction-fetch ports and a single-word, in-order backing instruction memory.
- Accepts one fetch-address request per transaction and issues FETCH_WIDTH sequential word reads.
- Assembles the returned words into one fetch line and buffers assembled lines in a small response FIFO.
- Presents lines to the core with a ready/valid handshake, so fetch is decoupled from memory latency.

Parameters:
- FETCH_WIDTH, 2: instructions per fetch line; uarch_pkg constant.
- CPU_ADDR_BITS, 32: byte address width; riscv_isa_pkg constant.
- CPU_INST_BITS, 32: instruction word width; riscv_isa_pkg constant.
- RSP_FIFO_DEPTH, 2: number of assembled lines buffered; must be ≥1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_val  in  1  core fetch request valid.
- imem_req_rdy  out  1  bridge can accept a request.
- imem_req_packet  in  CPU_ADDR_BITS  fetch base byte address.
- imem_rec_val  out  1  assembled line valid.
- imem_rec_rdy  in  1  core consumes the line.
- imem_rec_packet  out  FETCH_WIDTH*CPU_INST_BITS  line; word i at bits [i*32 +: 32].
- mem_req_val  out  1  backing memory read valid.
- mem_req_rdy  in  1  backing memory accepts the read.
- mem_req_addr  out  CPU_ADDR_BITS  word-aligned byte address.
- mem_rsp_val  in  1  read data valid; in order, no backpressure, latency ≥1.
- mem_rsp_data  in  CPU_INST_BITS  read data.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE; issue/response counters clear; FIFO empties.
  - Outputs during reset: imem_rec_val=0, imem_rec_packet=0, mem_req_val=0, mem_req_addr=0, err=0.
  - imem_req_rdy is combinational and reads 1 once reset state is IDLE with an empty FIFO.
  - The backing memory shares rst; no response may arrive for a pre-reset read.
- State IDLE:
  - imem_req_rdy = (fifo_count < RSP_FIFO_DEPTH).
  - On imem_req_val && imem_req_rdy: latch base = {addr[CPU_ADDR_BITS-1:2], 2'b00} (low two bits ignored); clear issue_cnt and rsp_cnt; go to FETCH.
- State FETCH:
  - imem_req_rdy=0.
  - mem_req_val = (issue_cnt < FETCH_WIDTH).
  - mem_req_addr = base + 4*issue_cnt, modulo 2^CPU_ADDR_BITS; 0xFFFFFFFC+4 wraps to 0.
  - issue_cnt increments on each mem_req_val && mem_req_rdy; issues may be back-to-back.
  - Responses may overlap issue in the same cycle.
  - Each mem_rsp_val writes mem_rsp_data into line slot rsp_cnt, then rsp_cnt increments.
- Completion:
  - On the cycle the FETCH_WIDTH-th response arrives, the assembled line (including that word) is pushed into the FIFO; state returns to IDLE.
  - imem_rec_val rises the following cycle.
  - Nothing is pushed on a full FIFO: acceptance guaranteed a free slot, only one transaction is in flight, and pops only free space.
- FIFO output:
  - imem_rec_val = !empty; imem_rec_packet = head entry (0 when empty).
  - Pop on imem_rec_val && imem_rec_rdy.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Read/write pointers wrap modulo RSP_FIFO_DEPTH.
- Protocol error:
  - mem_rsp_val while in IDLE, or with rsp_cnt ≥ issue_cnt, is ignored and sets err.
  - err clears only on rst.
- Minimum latency, memory always ready with 1-cycle response: request accepted at T; beats at T+1 and T+2; responses at T+2 and T+3; imem_rec_val at T+4.
- A new request may be accepted in the cycle after completion if FIFO space remains.

Decomposition:
- uarch_pkg: add IMEM_RSP_FIFO_DEPTH and enum imem_bridge_state_t {IBR_IDLE, IBR_FETCH}.
- FETCH_WIDTH, CPU_ADDR_BITS and CPU_INST_BITS stay in their existing packages.
- One sub-module, line_fifo: parameterized width/depth synchronous FIFO with push, pop, full, empty and count outputs, asynchronous active-high reset.

Test Plan:
- Reset, then req 0x0000_1000, memory returns 0x00000013 then 0x00100093 with 1-cycle latency → mem_req_addr 0x1000 then 0x1004; imem_rec_val at T+4; packet 0x00100093_00000013.
- Request 0x0000_2006 → low bits dropped; addresses 0x2004 and 0x2008 issued.
- Request 0xFFFF_FFFC → second beat address 0x0000_0000.
- mem_req_rdy low 3 cycles, response latency 5 → mem_req_val and mem_req_addr held stable during stall; line correct; imem_req_rdy=0 throughout FETCH.
- imem_rec_rdy=0, RSP_FIFO_DEPTH=2, two requests completed → imem_req_rdy=0 in IDLE. Raise imem_rec_rdy for one cycle → imem_req_rdy returns to 1 next cycle; lines pop in order.
- Stray mem_rsp_val in IDLE → err=1 and stays 1; FIFO unchanged.
- Assert rst mid-FETCH → outputs return to reset values immediately and the FIFO is empty.
